soc_bus_bridge: RTL and testbench

//  Parametrised memory-mapped bridge between the CPU data port and NUM_SLAVES slaves
//  (RAM, CP0-visible MMIO, timers, ...). Replaces direct CPU-to-RAM wiring in the SoC top.

---
 rtl/soc_bus_pkg.sv | 31 +++
 rtl/soc_addr_decoder.sv | 30 +++
 rtl/soc_bus_bridge.sv | 190 +++++++++++++++++++
 tb/tb_soc_bus_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the CPU-to-slave bus bridge.
`timescale 1ns/1ps
package soc_bus_pkg;

  // Bridge transaction phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Exception codes handed back to the CPU for CP0
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Access size encodings on cpu_mask (2'b11 is reserved and behaves as a word)
  localparam logic [1:0] MASK_WORD = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_BYTE = 2'b10;

  // True when the low address bits do not suit the access size
  function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] addr_lo);
    case (mask)
      MASK_HALF: return addr_lo[0];
      MASK_BYTE: return 1'b0;
      default:   return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/soc_addr_decoder.sv
// Combinational region decoder: per-slave hit, lowest-index one-hot select, miss flag.
`timescale 1ns/1ps
module soc_addr_decoder
  import soc_bus_pkg::*;
#(
  parameter int                          NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE = {32'h4000_0000, 32'h3000_0000,
                                                       32'h2000_0000, 32'h1000_0000},
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                                       32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] sel_onehot,
  output logic                  miss
);

  logic [NUM_SLAVES-1:0] hit;

  // One comparator per region; overlapping regions may hit together
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      assign hit[gi] = ((addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32]);
    end
  endgenerate

  // Isolate the lowest set bit so the lowest-index slave wins on overlap
  assign sel_onehot = hit & (~hit + NUM_SLAVES'(1));
  assign miss       = ~|hit;

endmodule

// File: rtl/soc_bus_bridge.sv
// CPU data port to NUM_SLAVES slave bridge: decode, alignment check, req/ack with timeout.
`timescale 1ns/1ps
module soc_bus_bridge
  import soc_bus_pkg::*;
#(
  parameter int                          NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE = {32'h4000_0000, 32'h3000_0000,
                                                       32'h2000_0000, 32'h1000_0000},
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                                       32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                          TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [1:0]               cpu_mask,
  input  logic                     cpu_signed_ext,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              bus_cpu_rdata,
  output logic                     bus_cpu_ready,
  output logic                     bus_cpu_err,
  output logic [4:0]               bus_cpu_cause,
  output logic [NUM_SLAVES-1:0]    slv_sel,
  output logic                     slv_we,
  output logic [31:0]              slv_addr,
  output logic [1:0]               slv_mask,
  output logic                     slv_signed_ext,
  output logic [31:0]              slv_wdata,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_ack
);

  localparam int             CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

  bus_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d, sext_q, sext_d;
  logic [31:0]           addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]            mask_q, mask_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [31:0]           cap_q, cap_d;
  logic                  err_pend_q, err_pend_d;
  logic [4:0]            cause_pend_q, cause_pend_d;
  logic                  ready_q, ready_d, err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [4:0]            cause_q, cause_d;

  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  dec_miss;
  logic                  ack_hit;
  logic [31:0]           sel_rdata;

  soc_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr       (cpu_addr),
    .sel_onehot (dec_onehot),
    .miss       (dec_miss)
  );

  // Only the selected slave's ack counts; pick its read data
  assign ack_hit = |(slv_ack & sel_q);
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = slv_rdata[i*32 +: 32];
    end
  end

  // Next-state and registered-output logic for the transaction FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    sext_d       = sext_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    cap_d        = cap_q;
    err_pend_d   = err_pend_q;
    cause_pend_d = cause_pend_q;
    ready_d      = 1'b0;
    err_d        = 1'b0;
    cause_d      = 5'd0;
    rdata_d      = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          mask_d  = cpu_mask;
          sext_d  = cpu_signed_ext;
          wdata_d = cpu_wdata;
          cap_d   = 32'd0;
          if (is_misaligned(cpu_mask, cpu_addr[1:0])) begin
            err_pend_d   = 1'b1;
            cause_pend_d = cpu_we ? EXC_ADES : EXC_ADEL;
            state_d      = ST_RESP;
          end else if (dec_miss) begin
            err_pend_d   = 1'b1;
            cause_pend_d = EXC_DBE;
            state_d      = ST_RESP;
          end else begin
            err_pend_d   = 1'b0;
            cause_pend_d = 5'd0;
            sel_d        = dec_onehot;
            cnt_d        = '0;
            state_d      = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (ack_hit) begin
          cap_d   = sel_rdata;
          sel_d   = '0;
          state_d = ST_RESP;
        end else if (cnt_q == TMO) begin
          err_pend_d   = 1'b1;
          cause_pend_d = EXC_DBE;
          sel_d        = '0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        err_d   = err_pend_q;
        cause_d = err_pend_q ? cause_pend_q : 5'd0;
        rdata_d = err_pend_q ? 32'd0 : cap_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latches and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      mask_q       <= 2'b00;
      sext_q       <= 1'b0;
      wdata_q      <= 32'd0;
      sel_q        <= '0;
      cap_q        <= 32'd0;
      err_pend_q   <= 1'b0;
      cause_pend_q <= 5'd0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      cause_q      <= 5'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      sext_q       <= sext_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      cap_q        <= cap_d;
      err_pend_q   <= err_pend_d;
      cause_pend_q <= cause_pend_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      cause_q      <= cause_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus_cpu_rdata  = rdata_q;
  assign bus_cpu_ready  = ready_q;
  assign bus_cpu_err    = err_q;
  assign bus_cpu_cause  = cause_q;
  assign slv_sel        = sel_q;
  assign slv_we         = we_q;
  assign slv_addr       = addr_q;
  assign slv_mask       = mask_q;
  assign slv_signed_ext = sext_q;
  assign slv_wdata      = wdata_q;

endmodule

// File: tb/tb_soc_bus_bridge.sv
// Scoreboard bench for soc_bus_bridge: expectations queued at request, checked at ready.
`timescale 1ns/1ps
module tb_soc_bus_bridge;
  import soc_bus_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 255;
  // Slave3 covers all of 0x1xxx_xxxx and so overlaps slave0
  localparam logic [NS*32-1:0] BASES = {32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic          clk, rst;
  logic          cpu_req, cpu_we, cpu_signed_ext;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic [1:0]    cpu_mask;
  logic [31:0]   bus_cpu_rdata;
  logic          bus_cpu_ready, bus_cpu_err;
  logic [4:0]    bus_cpu_cause;
  logic [NS-1:0] slv_sel, slv_ack;
  logic          slv_we, slv_signed_ext;
  logic [31:0]   slv_addr, slv_wdata;
  logic [1:0]    slv_mask;
  logic [NS*32-1:0] slv_rdata;
  logic [31:0]   rd [NS];

  assign slv_rdata = {rd[3], rd[2], rd[1], rd[0]};

  soc_bus_bridge #(
    .NUM_SLAVES (NS), .SLAVE_BASE (BASES), .SLAVE_MASK (MASKS), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset (rst),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_mask (cpu_mask),
    .cpu_signed_ext (cpu_signed_ext), .cpu_wdata (cpu_wdata),
    .bus_cpu_rdata (bus_cpu_rdata), .bus_cpu_ready (bus_cpu_ready),
    .bus_cpu_err (bus_cpu_err), .bus_cpu_cause (bus_cpu_cause),
    .slv_sel (slv_sel), .slv_we (slv_we), .slv_addr (slv_addr), .slv_mask (slv_mask),
    .slv_signed_ext (slv_signed_ext), .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata), .slv_ack (slv_ack)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  cause;
    logic [3:0]  sel;
    int          sel_cyc;
    int          req_edge;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   cur_ack_at = 0, rogue_idx = 0, rogue_at = 0;
  int   acc = 0, sel_cyc_seen = 0;
  logic [NS-1:0] sel_seen, ack_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Slave responder and response monitor, both evaluated on the falling edge
  initial begin
    sel_seen = '0;
    slv_ack  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = 0; slv_ack = '0; sel_seen = '0; sel_cyc_seen = 0;
      end else begin
        if (slv_sel != '0) begin
          acc++;
          sel_cyc_seen++;
          sel_seen = sel_seen | slv_sel;
          ack_v = '0;
          for (int i = 0; i < NS; i++) if (slv_sel[i] && cur_ack_at == acc) ack_v[i] = 1'b1;
          if (rogue_at == acc) ack_v[rogue_idx] = 1'b1;
          slv_ack = ack_v;
        end else begin
          acc = 0;
          slv_ack = '0;
        end
        if (bus_cpu_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, ":rdata"}, bus_cpu_rdata, mon_e.rdata);
            chk({mon_e.name, ":err"}, 32'(bus_cpu_err), 32'(mon_e.err));
            chk({mon_e.name, ":cause"}, 32'(bus_cpu_cause), 32'(mon_e.cause));
            chk({mon_e.name, ":latency"}, 32'(cyc - mon_e.req_edge), 32'(mon_e.lat));
            chk({mon_e.name, ":sel_seen"}, 32'(sel_seen), 32'(mon_e.sel));
            chk({mon_e.name, ":sel_cycles"}, 32'(sel_cyc_seen), 32'(mon_e.sel_cyc));
            $display("txn %s: rdata=%h err=%0d cause=%0d latency=%0d sel=%b",
                     mon_e.name, bus_cpu_rdata, bus_cpu_err, bus_cpu_cause,
                     cyc - mon_e.req_edge, sel_seen);
          end
          sel_seen = '0;
          sel_cyc_seen = 0;
        end
      end
    end
  end

  // Drive one request, queue its expected response and wait (bounded) for it
  task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] mask, input logic sext, input logic [31:0] wdata,
                        input int ack_at, input int r_idx, input int r_at,
                        input logic [3:0] exp_sel, input logic exp_err, input logic [4:0] exp_cause);
    exp_t e;
    int   idx;
    @(negedge clk);
    cur_ack_at = ack_at; rogue_idx = r_idx; rogue_at = r_at;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_mask = mask;
    cpu_signed_ext = sext; cpu_wdata = wdata;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    e.name = name; e.req_edge = cyc; e.err = exp_err; e.cause = exp_cause; e.sel = exp_sel;
    if (exp_sel == '0) begin
      e.lat = 1; e.sel_cyc = 0; e.rdata = 32'd0;
    end else begin
      idx = 0;
      for (int i = 0; i < NS; i++) if (exp_sel[i]) idx = i;
      if (ack_at >= 1 && ack_at <= TMO + 1) begin
        e.lat = ack_at + 1; e.sel_cyc = ack_at; e.rdata = rd[idx];
      end else begin
        e.lat = TMO + 2; e.sel_cyc = TMO + 1; e.rdata = 32'd0;
      end
      chk({name, ":slv_sel"}, 32'(slv_sel), 32'(exp_sel));
      chk({name, ":slv_addr"}, slv_addr, addr);
      chk({name, ":slv_we"}, 32'(slv_we), 32'(we));
      chk({name, ":slv_mask"}, 32'(slv_mask), 32'(mask));
      chk({name, ":slv_sext"}, 32'(slv_signed_ext), 32'(sext));
      chk({name, ":slv_wdata"}, slv_wdata, wdata);
    end
    exp_q.push_back(e);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    chk({name, ":ready_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_mask = 2'b00;
    cpu_signed_ext = 1'b0; cpu_wdata = '0;
    rd[0] = 32'hDEAD_BEEF; rd[1] = 32'h1111_1111; rd[2] = 32'h2222_2222; rd[3] = 32'h3333_3333;
    repeat (3) @(negedge clk);
    chk("reset:ready", 32'(bus_cpu_ready), 32'd0);
    chk("reset:err", 32'(bus_cpu_err), 32'd0);
    chk("reset:cause", 32'(bus_cpu_cause), 32'd0);
    chk("reset:rdata", bus_cpu_rdata, 32'd0);
    chk("reset:slv_sel", 32'(slv_sel), 32'd0);
    chk("reset:slv_addr", slv_addr, 32'd0);
    rst = 1'b0;

    //     name            we    addr           mask       sx    wdata          ack r_i r_at sel      err   cause
    do_txn("ld_word_s0",   1'b0, 32'h1000_0010, MASK_WORD, 1'b0, 32'h0,         1,  0,  0,   4'b0001, 1'b0, 5'd0);
    do_txn("st_half_mis",  1'b1, 32'h1000_0003, MASK_HALF, 1'b0, 32'h0000_BEEF, 1,  0,  0,   4'b0000, 1'b1, EXC_ADES);
    do_txn("ld_byte_miss", 1'b0, 32'h7000_0000, MASK_BYTE, 1'b0, 32'h0,         1,  0,  0,   4'b0000, 1'b1, EXC_DBE);
    do_txn("ld_word_mis",  1'b0, 32'h1000_0002, MASK_WORD, 1'b0, 32'h0,         1,  0,  0,   4'b0000, 1'b1, EXC_ADEL);
    do_txn("ld_rsvd_mis",  1'b0, 32'h2000_0001, 2'b11,     1'b0, 32'h0,         1,  0,  0,   4'b0000, 1'b1, EXC_ADEL);
    do_txn("st_mis_miss",  1'b1, 32'h7000_0001, MASK_WORD, 1'b0, 32'h0,         1,  0,  0,   4'b0000, 1'b1, EXC_ADES);
    do_txn("st_byte_s0",   1'b1, 32'h1000_0003, MASK_BYTE, 1'b0, 32'h0000_00A5, 2,  0,  0,   4'b0001, 1'b0, 5'd0);
    do_txn("ld_half_s3",   1'b0, 32'h1001_0002, MASK_HALF, 1'b1, 32'h0,         1,  0,  0,   4'b1000, 1'b0, 5'd0);
    do_txn("rogue_ack",    1'b0, 32'h2000_0040, MASK_WORD, 1'b0, 32'h0,         3,  3,  1,   4'b0010, 1'b0, 5'd0);
    do_txn("timeout_s2",   1'b0, 32'h3000_0000, MASK_WORD, 1'b0, 32'h0,         0,  0,  0,   4'b0100, 1'b1, EXC_DBE);
    do_txn("ack_at_tmo",   1'b0, 32'h3000_0004, MASK_WORD, 1'b0, 32'h0,         256, 0, 0,   4'b0100, 1'b0, 5'd0);

    // Reset while a slave is being accessed: select and response flags drop at once
    @(negedge clk);
    cur_ack_at = 0; rogue_at = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000_0010; cpu_mask = MASK_WORD;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid:pre_sel", 32'(slv_sel), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid:slv_sel", 32'(slv_sel), 32'd0);
    chk("rst_mid:ready", 32'(bus_cpu_ready), 32'd0);
    chk("rst_mid:err", 32'(bus_cpu_err), 32'd0);
    chk("rst_mid:slv_addr", slv_addr, 32'd0);
    $display("txn rst_mid: reset asserted during access, sel=%b", slv_sel);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_txn("post_reset",   1'b0, 32'h3000_0008, MASK_WORD, 1'b0, 32'h0,         1,  0,  0,   4'b0100, 1'b0, 5'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
